motion_arbiter: RTL
===================

// Module: motion_arbiter
// PURPOSE
//  Sits between the line-tracker direction state and the two H-bridge motor channels of the kart.
//  Arbitrates three command sources: obstacle stop > manual override > line tracker.
//  Converts the winning 3-bit motion command into per-side direction pins and PWM.
//  Duty ramps per tick; a direction reversal runs ramp-down -> dead-time -> ramp-up.
// PARAMETERS
//  CLK_DIV_W   16      tick = 1 clk pulse every 2^CLK_DIV_W clk (free-running divider)
//  PWM_W       10      PWM counter/duty width; PWM period 2^PWM_W clk
//  DUTY_FWD    768     target duty for driven wheel(s)
//  RAMP_STEP   16      duty change per tick, toward target
//  DEAD_TICKS  8       ticks with pins 00 between opposite directions
//  HOLD_TICKS  200     ticks stop persists after obstacle deasserts
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high
//  track_state  in   3  tracker command (STOP 000, FWD 001, BACK 101, L 010, BL 110, R 011, BR 111)
//  obstacle     in   1  level, 1 = object too close
//  manual_en    in   1  1 = manual_cmd overrides tracker
//  manual_cmd   in   3  same encoding as track_state
//  left_motor   out  2  H-bridge IN1/IN2: 10 fwd, 01 back, 00 coast (11 never driven)
//  right_motor  out  2  same as left_motor
//  left_pwm     out  1  PWM enable, left channel
//  right_pwm    out  1  PWM enable, right channel
//  active_src   out  2  0 none, 1 tracker, 2 manual, 3 obstacle
// BEHAVIOUR
//  Reset (sync): divider, PWM counter, hold counter = 0; duties 0; motors 00; pwm 0; active_src 0; channels RUN/coast.
//  Select (registered, 1 clk):
//   - obstacle=1 or hold counter!=0 -> src 3.
//   - else manual_en -> src 2; else src 1.
//   - src 0 only out of reset until first select.
//  Hold counter: loaded HOLD_TICKS on obstacle fall; -1 per tick; reload if obstacle re-rises.
//  Decode (target dir, duty) per side:
//   - FWD: both fwd, DUTY_FWD; BACK: both back, DUTY_FWD.
//   - L: left fwd 0, right fwd DUTY_FWD. R: mirror of L.
//   - BL: left back 0, right back DUTY_FWD. BR: mirror of BL.
//   - STOP and undefined 100 -> both coast, duty 0.
//  Obstacle (src 3): duty forced 0 and pins 00 on the next clk, no ramp.
//   - On release, channels restart from coast with duty 0.
//  Channel FSM (per side), updates only on tick:
//   RUN    : target dir == cur dir, or cur dir coast:
//             adopt target dir; duty += / -= RAMP_STEP, saturating exactly at target (no overshoot, no wrap).
//   RUN    : target dir opposite, duty != 0 -> RAMPDN.
//   RUN    : target dir opposite, duty == 0 -> DEAD.
//   RAMPDN : duty -= RAMP_STEP, floor 0. At 0 -> DEAD.
//   RAMPDN : target returns to cur dir -> RUN (ramp up, no dead-time).
//   DEAD   : pins 00, counter DEAD_TICKS..1. At expiry -> RUN with latest target dir.
//   DEAD   : target changes inside DEAD do not restart the count.
//   Target coast: duty ramps to 0; pins keep cur dir until duty 0, then 00.
//  PWM: shared free-running PWM_W counter; pwm = (pwm_cnt < duty).
//   - duty 0 -> constant 0; pwm forced 0 whenever pins = 00.
//  Latency:
//   - input change -> active_src: 1 clk.
//   - input change -> first duty step: next tick after select.
//  Mid-operation reset: all outputs reach reset values at the same edge.
// STRUCTURE
//  Package kart_pkg: command codes (STOP..BACKRIGHT), motor pin codes (FWD/BACK/COAST), src codes.
//  Sub-module motor_channel (x2): ramp, RUN/RAMPDN/DEAD FSM, dead-time counter, PWM compare.
//  Top: divider, arbiter, hold counter, decoder, shared PWM counter.
// TESTING (bench params: CLK_DIV_W=4, PWM_W=4, DUTY_FWD=12, RAMP_STEP=4, DEAD_TICKS=2, HOLD_TICKS=3)
//  1. Reset, track_state=001 -> src 1 after 1 clk; both pins 10.
//     Duty 4, 8, 12 on successive ticks, then holds 12; pwm high 12 of 16 clk.
//  2. At duty 12, track_state=101 -> duty 8, 4, 0 (pins 10).
//     Then pins 00 for 2 ticks, then 01 with duty 4, 8, 12.
//  3. Running 001, obstacle=1 -> next clk: src 3, pins 00, pwm 0.
//     Drop obstacle -> src stays 3 for 3 ticks, then 1; ramp restarts from 0.
//  4. manual_en=1, manual_cmd=010 while tracker=011 -> src 2.
//     Left duty -> 0, right ramps to 12; obstacle still preempts.
//  5. In RAMPDN (001 -> 101 at duty 8), return to 001 -> no dead-time; duty 4, 8, 12.
//  6. track_state=100 -> treated as STOP; reset asserted mid-DEAD -> all outputs 0 on that edge.

Source files
------------

// File: rtl/kart_pkg.sv
// Shared codes for the kart motion arbiter: motion commands, H-bridge pin codes,
// command-source codes, channel FSM states and the command-to-side decoder.
package kart_pkg;

  typedef enum logic [2:0] {
    CMD_STOP      = 3'b000,
    CMD_FWD       = 3'b001,
    CMD_LEFT      = 3'b010,
    CMD_RIGHT     = 3'b011,
    CMD_UNDEF     = 3'b100,
    CMD_BACK      = 3'b101,
    CMD_BACKLEFT  = 3'b110,
    CMD_BACKRIGHT = 3'b111
  } motion_cmd_e;

  typedef enum logic [1:0] {
    PIN_COAST = 2'b00,
    PIN_BACK  = 2'b01,
    PIN_FWD   = 2'b10
  } motor_pins_e;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_TRACK  = 2'd1,
    SRC_MANUAL = 2'd2,
    SRC_OBST   = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    CH_RUN    = 2'd0,
    CH_RAMPDN = 2'd1,
    CH_DEAD   = 2'd2
  } ch_state_e;

  // drive = 1 means the side targets the full forward duty, 0 means duty 0
  typedef struct packed {
    motor_pins_e dir;
    logic        drive;
  } side_target_t;

  typedef struct packed {
    side_target_t left;
    side_target_t right;
  } cmd_target_t;

  function automatic side_target_t side(input motor_pins_e dir, input logic drive);
    side_target_t s;
    s.dir   = dir;
    s.drive = drive;
    return s;
  endfunction

  // A turn keeps the inner wheel pointed the same way at duty 0 rather than
  // coasting, so it can pick the ramp up again without a dead-time.
  function automatic cmd_target_t decode_cmd(input logic [2:0] cmd);
    cmd_target_t t;
    t.left  = side(PIN_COAST, 1'b0);
    t.right = side(PIN_COAST, 1'b0);
    case (cmd)
      CMD_FWD: begin
        t.left  = side(PIN_FWD, 1'b1);
        t.right = side(PIN_FWD, 1'b1);
      end
      CMD_BACK: begin
        t.left  = side(PIN_BACK, 1'b1);
        t.right = side(PIN_BACK, 1'b1);
      end
      CMD_LEFT: begin
        t.left  = side(PIN_FWD, 1'b0);
        t.right = side(PIN_FWD, 1'b1);
      end
      CMD_RIGHT: begin
        t.left  = side(PIN_FWD, 1'b1);
        t.right = side(PIN_FWD, 1'b0);
      end
      CMD_BACKLEFT: begin
        t.left  = side(PIN_BACK, 1'b0);
        t.right = side(PIN_BACK, 1'b1);
      end
      CMD_BACKRIGHT: begin
        t.left  = side(PIN_BACK, 1'b1);
        t.right = side(PIN_BACK, 1'b0);
      end
      default: ;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One H-bridge side: duty ramp, RUN/RAMPDN/DEAD reversal FSM with dead-time
// counter, and the PWM compare against the shared counter.
module motor_channel
  import kart_pkg::*;
#(
  parameter int PWM_W      = 10,
  parameter int RAMP_STEP  = 16,
  parameter int DEAD_TICKS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             kill,
  input  logic [1:0]       tgt_dir,
  input  logic [PWM_W-1:0] tgt_duty,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic [1:0]       pins,
  output logic             pwm,
  output logic [1:0]       state
);

  localparam int DW = $clog2(DEAD_TICKS + 1);
  localparam logic [PWM_W-1:0] STEP = PWM_W'(RAMP_STEP);

  ch_state_e        state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [DW-1:0]    dead_q, dead_d;
  logic             opposite;

  // Moves one step toward tgt and lands exactly on it; never crosses or wraps.
  function automatic logic [PWM_W-1:0] ramp_toward(input logic [PWM_W-1:0] cur,
                                                   input logic [PWM_W-1:0] tgt);
    logic [PWM_W-1:0] r;
    r = cur;
    if (cur < tgt) begin
      r = ((tgt - cur) < STEP) ? tgt : cur + STEP;
    end else if (cur > tgt) begin
      r = ((cur - tgt) < STEP) ? tgt : cur - STEP;
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    duty_d   = duty_q;
    dead_d   = dead_q;
    opposite = ((tgt_dir == PIN_FWD) && (dir_q == PIN_BACK)) ||
               ((tgt_dir == PIN_BACK) && (dir_q == PIN_FWD));
    if (kill) begin
      state_d = CH_RUN;
      dir_d   = PIN_COAST;
      duty_d  = '0;
      dead_d  = '0;
    end else if (tick) begin
      case (state_q)
        CH_RUN, CH_RAMPDN: begin
          if (opposite) begin
            if (duty_q == '0) begin
              state_d = CH_DEAD;
              dir_d   = PIN_COAST;
              dead_d  = DW'(DEAD_TICKS);
            end else begin
              state_d = CH_RAMPDN;
              duty_d  = ramp_toward(duty_q, '0);
            end
          end else begin
            state_d = CH_RUN;
            if (tgt_dir == PIN_COAST) begin
              // pins hold the old direction while the wheel is still driven
              duty_d = ramp_toward(duty_q, '0);
              if (duty_d == '0) dir_d = PIN_COAST;
            end else begin
              dir_d  = tgt_dir;
              duty_d = ramp_toward(duty_q, tgt_duty);
            end
          end
        end
        CH_DEAD: begin
          if (dead_q <= DW'(1)) begin
            state_d = CH_RUN;
            dead_d  = '0;
            dir_d   = tgt_dir;
            duty_d  = (tgt_dir == PIN_COAST) ? '0 : ramp_toward('0, tgt_duty);
          end else begin
            dead_d = dead_q - DW'(1);
          end
        end
        default: state_d = CH_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CH_RUN;
      dir_q   <= PIN_COAST;
      duty_q  <= '0;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      duty_q  <= duty_d;
      dead_q  <= dead_d;
    end
  end

  assign pins  = dir_q;
  assign pwm   = (dir_q != PIN_COAST) && (pwm_cnt < duty_q);
  assign state = state_q;

endmodule

// File: rtl/motion_arbiter.sv
// Kart motion arbiter: tick divider, obstacle/manual/tracker source select with
// post-obstacle hold, command decode and shared PWM counter feeding two channels.
module motion_arbiter
  import kart_pkg::*;
#(
  parameter int CLK_DIV_W  = 16,
  parameter int PWM_W      = 10,
  parameter int DUTY_FWD   = 768,
  parameter int RAMP_STEP  = 16,
  parameter int DEAD_TICKS = 8,
  parameter int HOLD_TICKS = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] track_state,
  input  logic       obstacle,
  input  logic       manual_en,
  input  logic [2:0] manual_cmd,
  output logic [1:0] left_motor,
  output logic [1:0] right_motor,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic [1:0] active_src,
  output logic [1:0] dbg_left_state,
  output logic [1:0] dbg_right_state
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [PWM_W-1:0] DUTY = PWM_W'(DUTY_FWD);

  logic [CLK_DIV_W-1:0] div_q, div_d;
  logic [PWM_W-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic [HW-1:0]        hold_q, hold_d;
  src_e                 src_q, src_d;
  logic [2:0]           cmd_q, cmd_d;
  logic                 tick;
  logic                 kill;
  cmd_target_t          tgt;
  logic [PWM_W-1:0]     left_duty_tgt, right_duty_tgt;

  assign tick = (div_q == '1);

  always_comb begin
    div_d     = div_q + CLK_DIV_W'(1);
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    // Reloading every clock while the obstacle is present means the count
    // starts from HOLD_TICKS at the fall and restarts on every re-rise.
    hold_d = hold_q;
    if (obstacle) begin
      hold_d = HW'(HOLD_TICKS);
    end else if (tick && (hold_q != '0)) begin
      hold_d = hold_q - HW'(1);
    end
    if (obstacle || (hold_q != '0)) begin
      src_d = SRC_OBST;
    end else if (manual_en) begin
      src_d = SRC_MANUAL;
    end else begin
      src_d = SRC_TRACK;
    end
    cmd_d = manual_en ? manual_cmd : track_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      pwm_cnt_q <= '0;
      hold_q    <= '0;
      src_q     <= SRC_NONE;
      cmd_q     <= CMD_STOP;
    end else begin
      div_q     <= div_d;
      pwm_cnt_q <= pwm_cnt_d;
      hold_q    <= hold_d;
      src_q     <= src_d;
      cmd_q     <= cmd_d;
    end
  end

  // Kill follows the next-cycle source so the bridges drop with active_src.
  assign kill = (src_d == SRC_OBST);

  always_comb begin
    tgt = decode_cmd(((src_q == SRC_TRACK) || (src_q == SRC_MANUAL)) ? cmd_q : CMD_STOP);
    left_duty_tgt  = tgt.left.drive  ? DUTY : '0;
    right_duty_tgt = tgt.right.drive ? DUTY : '0;
  end

  motor_channel #(
    .PWM_W      (PWM_W),
    .RAMP_STEP  (RAMP_STEP),
    .DEAD_TICKS (DEAD_TICKS)
  ) u_left (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .kill     (kill),
    .tgt_dir  (tgt.left.dir),
    .tgt_duty (left_duty_tgt),
    .pwm_cnt  (pwm_cnt_q),
    .pins     (left_motor),
    .pwm      (left_pwm),
    .state    (dbg_left_state)
  );

  motor_channel #(
    .PWM_W      (PWM_W),
    .RAMP_STEP  (RAMP_STEP),
    .DEAD_TICKS (DEAD_TICKS)
  ) u_right (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .kill     (kill),
    .tgt_dir  (tgt.right.dir),
    .tgt_duty (right_duty_tgt),
    .pwm_cnt  (pwm_cnt_q),
    .pins     (right_motor),
    .pwm      (right_pwm),
    .state    (dbg_right_state)
  );

  assign active_src = src_q;

endmodule
